// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: state encoding shared by serial/parallel arithmetic blocks
package serial_subtractor_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_subtractor_f_subtractor.sv
// f_subtractor: 1-bit full subtractor
//   a, b : minuend / subtrahend bits
//   bi   : borrow in
//   d    : difference bit
//   bo   : borrow out
module f_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one bit per clock
//   clk, rst_n : clock, async active-low reset
//   start      : request, sampled only in IDLE
//   a, b       : operands, captured on acceptance
//   busy       : high while in RUN
//   done       : one-cycle pulse when diff/bo are valid
//   diff, bo   : result and final borrow, held until the next done
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bo
);
  localparam int CW = $clog2(WIDTH);
  state_t state, nxt;
  logic [WIDTH-1:0] sa, sb, sd;
  logic [CW-1:0] cnt;
  logic br, d, bn, last;
  assign last = cnt == CW'(WIDTH - 1);
  f_subtractor u_fs (.a(sa[0]), .b(sb[0]), .bi(br), .d(d), .bo(bn));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_comb
    nxt = state == S_IDLE ? (start ? S_RUN : S_IDLE) :
          state == S_RUN  ? (last ? S_DONE : S_RUN) : S_IDLE;
  always_comb begin
    busy = state == S_RUN;
    done = state == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      sd   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bo   <= 1'b0;
    end else if (state == S_IDLE) begin
      if (start) begin
        sa  <= a;
        sb  <= b;
        sd  <= '0;
        br  <= 1'b0;
        cnt <= '0;
      end
    end else if (state == S_RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      br  <= bn;
      sd  <= {d, sd[WIDTH-1:1]};
      cnt <= last ? '0 : cnt + CW'(1);
      if (last) begin
        diff <= {d, sd[WIDTH-1:1]};
        bo   <= bn;
      end
    end else if (state != S_DONE) begin
      // unreachable encoding: present reset-like outputs
      diff <= '0;
      bo   <= 1'b0;
    end
endmodule
